// File: rtl/seq_u_div16by8.sv
// ---------------------------------------------------------------------------
// seq_u_div16by8 -- sequential unsigned divider, 2N-bit dividend by N-bit
// divisor, restoring algorithm, one quotient bit per clock (MSB first).
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start_valid  : operands valid      start_ready : block accepts operands
//   dividend     : 2N-bit unsigned     divisor     : N-bit unsigned
//   res_valid    : result valid        res_ready   : consumer takes result
//   quotient     : N-bit quotient      remainder   : N-bit remainder
//   div_by_zero  : divisor was zero    overflow    : quotient exceeds N bits
//
// Build option
//   SEQ_DIV_REM_EN : when defined, remainder carries the real remainder;
//                    otherwise remainder is tied to zero and its result
//                    register is not built. Quotient, flags and timing are
//                    identical in both builds.
//
// Timing: the first quotient bit is produced on the accept edge itself, so
// a normal division enters DONE on the (N-1)th edge after accept and
// res_valid is seen N cycles after accept. Divide-by-zero and overflow
// enter DONE on the accept edge (res_valid seen 1 cycle after accept).
// ---------------------------------------------------------------------------
module seq_u_div16by8 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int          CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Working registers of the iteration
    logic [N-1:0]  r_prem;   // partial remainder
    logic [N-1:0]  r_pq;     // remaining dividend bits / quotient shift-in
    logic [N-1:0]  r_dvs;    // captured divisor
    logic [CW-1:0] r_cnt;    // quotient bits produced so far

    // Result registers
    logic [N-1:0]  r_quot;
    logic          r_dbz;
    logic          r_ovf;

    // Shared iteration datapath: in IDLE it works on the input operands so
    // the accept edge already yields the first quotient bit.
    logic          w_first;
    logic [N-1:0]  w_prem;
    logic [N-1:0]  w_pq;
    logic [N-1:0]  w_dvs;
    logic [N:0]    w_trial;
    logic          w_ge;
    logic [N-1:0]  w_nrem;
    logic [N-1:0]  w_nq;
    logic          w_dbz;
    logic          w_ovf;

    // Result load control
    logic          w_res_load;
    logic [N-1:0]  w_res_quot;
    logic [N-1:0]  w_res_rem;
    logic          w_res_dbz;
    logic          w_res_ovf;

    assign w_first = (r_state == IDLE);
    assign w_prem  = w_first ? dividend[2*N-1:N] : r_prem;
    assign w_pq    = w_first ? dividend[N-1:0]   : r_pq;
    assign w_dvs   = w_first ? divisor           : r_dvs;

    // Partial remainder is always < divisor, so trial < 2*divisor and the
    // difference fits back into N bits.
    assign w_trial = {w_prem, w_pq[N-1]};
    assign w_ge    = (w_trial >= {1'b0, w_dvs});
    assign w_nrem  = w_ge ? N'(w_trial - {1'b0, w_dvs}) : w_trial[N-1:0];
    assign w_nq    = (w_pq << 1) | N'(w_ge);

    assign w_dbz   = (divisor == {N{1'b0}});
    assign w_ovf   = (dividend[2*N-1:N] >= divisor);

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    if (w_dbz || w_ovf || (N == 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Decide when and what to load into the result registers
    always_comb begin
        w_res_load = 1'b0;
        w_res_quot = w_nq;
        w_res_rem  = w_nrem;
        w_res_dbz  = 1'b0;
        w_res_ovf  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_valid && w_dbz) begin
                    w_res_load = 1'b1;
                    w_res_quot = {N{1'b1}};
                    w_res_rem  = dividend[N-1:0];
                    w_res_dbz  = 1'b1;
                end else if (start_valid && w_ovf) begin
                    w_res_load = 1'b1;
                    w_res_quot = {N{1'b1}};
                    w_res_rem  = {N{1'b0}};
                    w_res_ovf  = 1'b1;
                end else if (start_valid && (N == 1)) begin
                    w_res_load = 1'b1;
                end else begin
                    w_res_load = 1'b0;
                end
            end
            BUSY: begin
                if (r_cnt == LAST) begin
                    w_res_load = 1'b1;
                end else begin
                    w_res_load = 1'b0;
                end
            end
            default: w_res_load = 1'b0;
        endcase
    end

    // Iteration registers: load on accept, step once per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prem <= {N{1'b0}};
            r_pq   <= {N{1'b0}};
            r_dvs  <= {N{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_prem <= w_nrem;
                        r_pq   <= w_nq;
                        r_dvs  <= divisor;
                        r_cnt  <= CW'(1);
                    end
                end
                BUSY: begin
                    r_prem <= w_nrem;
                    r_pq   <= w_nq;
                    r_cnt  <= r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Quotient and flag result registers; hold between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= {N{1'b0}};
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_res_load) begin
            r_quot <= w_res_quot;
            r_dbz  <= w_res_dbz;
            r_ovf  <= w_res_ovf;
        end
    end

`ifdef SEQ_DIV_REM_EN
    logic [N-1:0] r_rem;

    // Remainder result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= {N{1'b0}};
        end else if (w_res_load) begin
            r_rem <= w_res_rem;
        end
    end

    assign remainder = r_rem;
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_res_rem;
    assign remainder    = {N{1'b0}};
`endif

endmodule

// File: tb/tb_seq_u_div16by8.sv
module tb_seq_u_div16by8;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int total;
    int bad;

`ifdef SEQ_DIV_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    seq_u_div16by8 #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rem(input logic [7:0] r);
        return REM_EN ? r : 8'h00;
    endfunction

    // Drive one operation (entered #1 after a rising edge with DUT idle) and
    // return the number of cycles from the accept edge until res_valid.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
        start_valid = 1'b1;
        dividend    = dvd;
        divisor     = dvs;
        @(posedge clk); #1;
        start_valid = 1'b0;
        dividend    = 16'hA5A5;
        divisor     = 8'h5A;
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL rst_start_ready got=%b exp=1", start_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        total++; if ({quotient, remainder, div_by_zero, overflow} !== 18'h0) begin bad++; $display("FAIL rst_outputs got=%h/%h/%b/%b exp=0", quotient, remainder, div_by_zero, overflow); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        logic [15:0] dvd [5] = '{16'h03E8, 16'hFEFF, 16'h00FF, 16'hFE00, 16'h0000};
        logic [7:0]  dvs [5] = '{8'h07,    8'hFF,    8'h10,    8'hFF,    8'h05};
        logic [7:0]  eq  [5] = '{8'h8E,    8'hFF,    8'h0F,    8'hFE,    8'h00};
        logic [7:0]  er  [5] = '{8'h06,    8'hFE,    8'h0F,    8'hFE,    8'h00};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(dvd[i], dvs[i], lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL norm_latency[%0d] got=%0d exp=8", i, lat); end
            total++; if (quotient !== eq[i]) begin bad++; $display("FAIL norm_quot[%0d] got=%h exp=%h", i, quotient, eq[i]); end
            total++; if (remainder !== exp_rem(er[i])) begin bad++; $display("FAIL norm_rem[%0d] got=%h exp=%h", i, remainder, exp_rem(er[i])); end
            total++; if ({div_by_zero, overflow} !== 2'b00) begin bad++; $display("FAIL norm_flags[%0d] got=%b%b exp=00", i, div_by_zero, overflow); end
            consume();
        end
    endtask

    task automatic test_exceptions();
        logic [15:0] dvd [3] = '{16'h1234, 16'h0100, 16'h0700};
        logic [7:0]  dvs [3] = '{8'h00,    8'h01,    8'h07};
        logic [7:0]  er  [3] = '{8'h34,    8'h00,    8'h00};
        logic [1:0]  ef  [3] = '{2'b10,    2'b01,    2'b01};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(dvd[i], dvs[i], lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL exc_latency[%0d] got=%0d exp=1", i, lat); end
            total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL exc_quot[%0d] got=%h exp=ff", i, quotient); end
            total++; if (remainder !== exp_rem(er[i])) begin bad++; $display("FAIL exc_rem[%0d] got=%h exp=%h", i, remainder, exp_rem(er[i])); end
            total++; if ({div_by_zero, overflow} !== ef[i]) begin bad++; $display("FAIL exc_flags[%0d] got=%b%b exp=%b", i, div_by_zero, overflow, ef[i]); end
            consume();
        end
    endtask

    task automatic test_stall();
        int lat;
        run_op(16'h03E8, 8'h07, lat);
        // new operands offered during DONE must be ignored
        start_valid = 1'b1;
        dividend    = 16'h1234;
        divisor     = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if ({res_valid, start_ready} !== 2'b10) begin bad++; $display("FAIL stall_hs[%0d] got=%b%b exp=10", c, res_valid, start_ready); end
            total++; if ({quotient, remainder, div_by_zero, overflow} !== {8'h8E, exp_rem(8'h06), 2'b00}) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%b%b", c, quotient, remainder, div_by_zero, overflow); end
        end
        start_valid = 1'b0;
        consume();
        total++; if ({res_valid, start_ready} !== 2'b01) begin bad++; $display("FAIL stall_release got=%b%b exp=01", res_valid, start_ready); end
        @(posedge clk); #1;
        total++; if ({quotient, remainder, div_by_zero, overflow} !== {8'h8E, exp_rem(8'h06), 2'b00}) begin bad++; $display("FAIL idle_hold got=%h/%h/%b%b", quotient, remainder, div_by_zero, overflow); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'h0100, 8'h01, lat);
        // offer a divide-by-zero while the result is being consumed
        start_valid = 1'b1;
        dividend    = 16'h1234;
        divisor     = 8'h00;
        res_ready   = 1'b1;
        @(posedge clk); #1;
        res_ready   = 1'b0;
        total++; if ({res_valid, start_ready} !== 2'b01) begin bad++; $display("FAIL b2b_no_accept got=%b%b exp=01", res_valid, start_ready); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_prev_ovf got=%b exp=1", overflow); end
        @(posedge clk); #1;
        start_valid = 1'b0;
        total++; if ({res_valid, div_by_zero, remainder} !== {2'b11, exp_rem(8'h34)}) begin bad++; $display("FAIL b2b_next got=%b%b/%h exp=11/%h", res_valid, div_by_zero, remainder, exp_rem(8'h34)); end
        consume();
    endtask

    task automatic test_reset_midop();
        int lat;
        int seen;
        start_valid = 1'b1;
        dividend    = 16'h03E8;
        divisor     = 8'h07;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({start_ready, res_valid} !== 2'b10) begin bad++; $display("FAIL mid_rst_hs got=%b%b exp=10", start_ready, res_valid); end
        total++; if ({quotient, remainder, div_by_zero, overflow} !== 18'h0) begin bad++; $display("FAIL mid_rst_out got=%h/%h/%b%b exp=0", quotient, remainder, div_by_zero, overflow); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_no_result got=%0d exp=0", seen); end
        run_op(16'h0064, 8'h0A, lat);
        total++; if ({quotient, remainder} !== {8'h0A, exp_rem(8'h00)}) begin bad++; $display("FAIL post_rst_result got=%h/%h exp=0a/00", quotient, remainder); end
        total++; if (lat !== 8) begin bad++; $display("FAIL post_rst_latency got=%0d exp=8", lat); end
        consume();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        dividend    = 16'h0000;
        divisor     = 8'h00;
        test_reset();
        test_normal();
        test_exceptions();
        test_stall();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_u_div16by8.md
SEQ_U_DIV16BY8 -- requirements
Module: seq_u_div16by8

Interface
REQ-001 SHALL have parameter N, default 8: divisor, quotient and remainder width; dividend width is 2*N.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_valid  input  1  operands valid.
REQ-005 SHALL have port start_ready  output  1  block accepts operands.
REQ-006 SHALL have port dividend  input  2*N  unsigned dividend.
REQ-007 SHALL have port divisor  input  N  unsigned divisor.
REQ-008 SHALL have port res_valid  output  1  result valid.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quotient  output  N  unsigned quotient.
REQ-011 SHALL have port remainder  output  N  unsigned remainder (see Configuration).
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-013 SHALL have port overflow  output  1  quotient does not fit in N bits.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive start_ready high only in IDLE and res_valid high only in DONE.
REQ-016 SHALL accept operands on an edge where start_valid and start_ready are both high; the operands are captured internally and may change afterwards.
REQ-017 SHALL, on accept with divisor == 0, go to DONE with quotient = all ones, remainder = dividend[N-1:0], div_by_zero = 1, overflow = 0.
REQ-018 SHALL, on accept with divisor != 0 and dividend[2N-1:N] >= divisor, go to DONE with quotient = all ones, remainder = 0, overflow = 1, div_by_zero = 0.
REQ-019 SHALL otherwise go to BUSY and perform restoring division, producing one quotient bit per cycle MSB-first over exactly N edges, then enter DONE.
REQ-020 SHALL make res_valid visible 1 cycle after the accept edge for the exception cases and N cycles after the accept edge for the normal case.
REQ-021 SHALL make the normal result satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-022 SHALL hold quotient, remainder and flags stable for the whole of DONE and return to IDLE on the edge where res_valid and res_ready are both high.
REQ-023 SHALL NOT accept new operands in the same cycle a result is consumed; the earliest next accept is the following cycle.
REQ-024 SHALL ignore start_valid in BUSY and DONE.
REQ-025 SHALL hold the last result on quotient, remainder and flags while in IDLE until the next result is produced.

Reset
REQ-026 SHALL, while rst_n is low, force the state to IDLE, start_ready = 1, res_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0 and overflow = 0, independent of clk.
REQ-027 SHALL discard any in-flight operation on reset assertion in BUSY or DONE, with no result delivered afterwards.

Configuration
REQ-028 SHALL use macro SEQ_DIV_REM_EN to control the remainder output.
REQ-029 SHALL, with SEQ_DIV_REM_EN defined, drive remainder as specified above.
REQ-030 SHALL, without SEQ_DIV_REM_EN, tie remainder to 0, omit the final remainder register, and leave quotient, flags and timing unchanged.

Verification
REQ-031 SHALL check: dividend 0x03E8, divisor 0x07 -> quotient 0x8E, remainder 0x06, flags 0, res_valid 8 cycles after accept.
REQ-032 SHALL check: dividend 0xFEFF, divisor 0xFF -> quotient 0xFF, remainder 0xFE, overflow 0.
REQ-033 SHALL check: dividend 0x1234, divisor 0x00 -> div_by_zero 1, quotient 0xFF, remainder 0x34, res_valid 1 cycle after accept; dividend 0x0100, divisor 0x01 -> overflow 1, quotient 0xFF, remainder 0x00.
REQ-034 SHALL check: res_ready held low 5 cycles in DONE -> outputs stable, start_ready 0; then res_ready high -> IDLE next edge, start_ready 1 the following cycle.
REQ-035 SHALL check: rst_n pulsed low at iteration 3 of 0x03E8/0x07 -> immediate IDLE with all outputs 0 and no res_valid afterwards; a new 0x0064/0x0A then yields quotient 0x0A, remainder 0x00.
REQ-036 SHALL check: build without SEQ_DIV_REM_EN, 0x03E8/0x07 -> quotient 0x8E, remainder 0x00, same latency.
